// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Op issue and result delivery channels of the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result,
        input  zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result,
        output zero, negative, carry, overflow
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] prod_next,
    output logic [2*WIDTH-1:0] prod
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               run;

    // prod_next lets the caller capture the product on the final step edge
    assign last      = run && (cnt == SHW'(WIDTH - 1));
    assign prod_next = acc + (mplier[0] ? mcand : '0);
    assign prod      = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            run    <= !last;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and a multi-cycle MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t             state;
    logic               live;
    logic               out_valid;
    logic [WIDTH-1:0]   result;
    flags_t             fl;
    logic               out_free;
    logic               accept;
    logic               mul_start;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_p;
    logic [WIDTH-1:0]   p_lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   alu_res;
    flags_t             alu_fl;
    flags_t             mul_fl;

    // live holds in_ready low until the first edge after reset release
    assign out_free     = !out_valid || bus.out_ready;
    assign bus.in_ready = live && (state == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_start    = accept && (bus.alu_control == OP_MUL);

    assign sh   = bus.b[SHW-1:0];
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        alu_res = '0;
        alu_fl  = '0;
        unique case (bus.alu_control)
            OP_ADD: begin
                alu_res         = sum[WIDTH-1:0];
                alu_fl.carry    = sum[WIDTH];
                alu_fl.overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                               && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res         = diff[WIDTH-1:0];
                alu_fl.carry    = !diff[WIDTH];
                alu_fl.overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                               && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:  alu_res = bus.a | bus.b;
            OP_AND: alu_res = bus.a & bus.b;
            OP_SLL: alu_res = bus.a << sh;
            OP_SRL: alu_res = bus.a >> sh;
            OP_SRA: alu_res = WIDTH'($signed(bus.a) >>> sh);
            OP_MUL: alu_res = '0;
        endcase
        alu_fl.zero     = (alu_res == '0);
        alu_fl.negative = alu_res[WIDTH-1];
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .a         (bus.a),
        .b         (bus.b),
        .last      (mul_last),
        .prod_next (mul_next),
        .prod      (mul_prod)
    );

    assign mul_p  = (state == MUL) ? mul_next : mul_prod;
    assign p_lo   = mul_p[WIDTH-1:0];
    assign mul_fl = '{
        zero:     (p_lo == '0),
        negative: p_lo[WIDTH-1],
        carry:    1'b0,
        overflow: |mul_p[2*WIDTH-1:WIDTH]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            fl        <= '0;
        end else begin
            live <= 1'b1;
            if (bus.out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mul_start) begin
                        state <= MUL;
                    end else if (accept) begin
                        result    <= alu_res;
                        fl        <= alu_fl;
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        if (out_free) begin
                            result    <= p_lo;
                            fl        <= mul_fl;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= MUL_DONE;
                        end
                    end
                end
                MUL_DONE: begin
                    if (out_free) begin
                        result    <= p_lo;
                        fl        <= mul_fl;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.zero      = fl.zero;
    assign bus.negative  = fl.negative;
    assign bus.carry     = fl.carry;
    assign bus.overflow  = fl.overflow;
endmodule
